ahb_apb_bridge: RTL
===================

# ahb_apb_bridge

AHB-Lite slave that terminates the CPU data-side AHB port (the address space above 0x0003_FFFF) and converts each single transfer into an APB4 transfer to one of NSLV peripherals. It sits directly downstream of the CPU data-memory/AHB arbiter: it consumes that arbiter's HADDR/HTRANS/HWRITE/HSIZE/HWDATA and returns HREADY/HRESP/HRDATA. Only single (NONSEQ) transfers are supported, with no bursts and no locking. Behaviour is fully sequential and wait-stated through a small FSM.

## Interface
Parameters:
- NSLV, 4: number of APB slaves (1..16).
- SEL_LSB, 12: lowest HADDR bit of the slave index; each slave owns a 2^SEL_LSB-byte window.
- TIMEOUT, 255: maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- ahb_hsel_i  in  1  bridge selected.
- ahb_haddr_i  in  32  address.
- ahb_hwrite_i  in  1  1 = write.
- ahb_hsize_i  in  3  transfer size.
- ahb_htrans_i  in  2  transfer type.
- ahb_hwdata_i  in  32  write data (data phase).
- ahb_hready_i  in  1  bus-level HREADY.
- ahb_hready_o  out  1  HREADYOUT.
- ahb_hresp_o  out  1  0 = OKAY, 1 = ERROR.
- ahb_hrdata_o  out  32  read data.
- apb_paddr_o  out  32  PADDR.
- apb_psel_o  out  NSLV  one-hot PSEL.
- apb_penable_o  out  1  PENABLE.
- apb_pwrite_o  out  1  PWRITE.
- apb_pwdata_o  out  32  PWDATA.
- apb_pstrb_o  out  4  PSTRB.
- apb_pready_i  in  NSLV  per-slave PREADY.
- apb_pslverr_i  in  NSLV  per-slave PSLVERR.
- apb_prdata_i  in  32*NSLV  per-slave PRDATA; slave k occupies bits [32k+31:32k].

## Operation
- Reset: ahb_hready_o=1, ahb_hresp_o=0, ahb_hrdata_o=0. All APB outputs are 0 (psel, penable, paddr, pwrite, pwdata, pstrb).
- Accept condition: state IDLE & hsel_i & hready_i & htrans_i==NONSEQ. On accept, register haddr, hwrite, hsize and the decode result.
- HTRANS IDLE/BUSY, or hsel_i low: zero-wait OKAY, no APB activity.
- Slave index: idx = haddr[SEL_LSB +: clog2(NSLV)].
- Decode errors cause no APB transfer; the FSM goes LATCH -> ERR_1. The error cases are:
  - idx >= NSLV;
  - hsize > 2;
  - halfword with haddr[0]=1;
  - word with haddr[1:0]!=0.
- Write strobes: byte 1<<haddr[1:0]; half haddr[1]?4'b1100:4'b0011; word 4'b1111. Reads drive pstrb=0.
- PADDR carries the full registered HADDR. PWDATA is registered from hwdata_i in LATCH.
- FSM states:
  - IDLE: hready_o=1. On accept, go to LATCH.
  - LATCH: hready_o=0; capture hwdata. Go to ERR_1 if a decode error was registered, else to SETUP.
  - SETUP: psel[idx]=1, penable=0. Go to ACCESS.
  - ACCESS: psel[idx]=1, penable=1; timeout counter increments.
    - On pready[idx]: capture prdata on reads (hrdata holds otherwise). Go to ERR_1 if pslverr[idx], else to IDLE.
    - On counter reaching TIMEOUT with no pready: drop psel/penable and go to ERR_1.
  - ERR_1: hresp=1, hready_o=0. Go to ERR_2.
  - ERR_2: hresp=1, hready_o=1. Go to IDLE. A new transfer is not accepted in this cycle; the AHB master cancels.
- Timeout counter width is clog2(TIMEOUT+1). It clears on entry to SETUP.
- Reset asserted mid-transfer: the transfer is abandoned and all outputs return to reset values at the next edge.

## Timing
- Write/read with zero-wait APB slave:
  - address phase in cycle N (IDLE);
  - LATCH at N+1, SETUP at N+2, ACCESS at N+3;
  - N+4 is IDLE with hready_o=1 and hrdata valid. The data phase completes at N+4.
- Each APB wait state adds one cycle.
- Back-to-back: a new address phase is accepted in the IDLE completion cycle.
- Decode error: ERR_1 at N+2, ERR_2 at N+3; psel stays 0 throughout.
- pwdata, paddr, pwrite and pstrb are stable from SETUP through the last ACCESS cycle.

## Structure
- Package ahb_apb_pkg holds the state_t enum (IDLE, LATCH, SETUP, ACCESS, ERR_1, ERR_2; 3 bits) and the strobe/decode function.
- HTRANS_* and HSIZE_* constants come from the shared ahb_intf.vh.
- Sub-module apb_slave_decode is combinational. Inputs: haddr, hsize, hwrite. Outputs: idx, one-hot sel, pstrb, err.

## Test plan
- Word write to 0x0004_1000 of 0xDEADBEEF, slave1 pready=1: psel=4'b0010 in SETUP, penable in ACCESS, pstrb=4'hF, hready_o returns high at N+4 with hresp=0.
- Byte read from 0x0004_2003, slave2 prdata=0x11223344, 2 wait states: pstrb=0, ACCESS lasts 3 cycles, hrdata=0x11223344 at N+6.
- Halfword write to 0x0004_0001: no psel asserted; hresp=1 with hready_o=0 then 1 (ERR_1, ERR_2).
- Slave0 returns pslverr=1 on a read: two-cycle ERROR response; hrdata unchanged.
- Slave3 never asserts pready: after 255 ACCESS cycles psel and penable drop, then the ERROR response.
- resetn low during ACCESS: next edge psel=0, penable=0, hready_o=1. A following word write completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge_pkg.sv
// ahb_apb_pkg: shared types, bus encodings and decode helpers for the AHB-to-APB bridge.
//   state_t         : bridge FSM states (3-bit encoding)
//   HTRANS_* / HSIZE_*: AHB-Lite transfer type and size encodings
//   size_align_err  : flags unsupported sizes and misaligned halfword/word addresses
//   write_strobe    : APB PSTRB for a transfer (all zero for reads)
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR_1  = 3'd4,
    ERR_2  = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  function automatic logic size_align_err(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    case (hsize)
      HSIZE_BYTE: err = 1'b0;
      HSIZE_HALF: err = addr_lo[0];
      HSIZE_WORD: err = (addr_lo != 2'b00);
      default:    err = 1'b1;  // wider than the 32-bit APB data path
    endcase
    return err;
  endfunction

  function automatic logic [3:0] write_strobe(input logic [2:0] hsize, input logic [1:0] addr_lo,
                                              input logic hwrite);
    logic [3:0] strb;
    strb = 4'b0000;
    if (hwrite) begin
      case (hsize)
        HSIZE_BYTE: strb = 4'b0001 << addr_lo;
        HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
        HSIZE_WORD: strb = 4'b1111;
        default:    strb = 4'b0000;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// ahb_apb_bridge_if: AHB-Lite slave port plus APB4 master port of the bridge.
//   AHB request : hsel, haddr, hwrite, hsize, htrans, hwdata, hready (bus-level)
//   AHB response: hreadyout, hresp, hrdata
//   APB request : paddr, psel (one-hot, NSLV wide), penable, pwrite, pwdata, pstrb
//   APB response: pready, pslverr (per slave), prdata (slave k at bits [32k+31:32k])
// Modport slave is the bridge's view; modport master is the surrounding system's view.
interface ahb_apb_bridge_if #(
  parameter int NSLV = 4
);
  logic                   hsel;
  logic [31:0]            haddr;
  logic                   hwrite;
  logic [2:0]             hsize;
  logic [1:0]             htrans;
  logic [31:0]            hwdata;
  logic                   hready;
  logic                   hreadyout;
  logic                   hresp;
  logic [31:0]            hrdata;

  logic [31:0]            paddr;
  logic [NSLV-1:0]        psel;
  logic                   penable;
  logic                   pwrite;
  logic [31:0]            pwdata;
  logic [3:0]             pstrb;
  logic [NSLV-1:0]        pready;
  logic [NSLV-1:0]        pslverr;
  logic [32*NSLV-1:0]     prdata;

  modport slave (
    input  hsel, haddr, hwrite, hsize, htrans, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport master (
    output hsel, haddr, hwrite, hsize, htrans, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/ahb_apb_bridge_decode.sv
// apb_slave_decode: combinational address/size decode for one AHB address phase.
//   haddr, hsize, hwrite : AHB address-phase attributes
//   idx                  : slave index, haddr[SEL_LSB +: clog2(NSLV)]
//   sel                  : one-hot slave select derived from idx
//   pstrb                : APB write strobes (zero for reads)
//   err                  : decode error (index out of range, bad size or misalignment)
module apb_slave_decode
  import ahb_apb_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  localparam int IDXW   = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [31:0]     haddr,
  input  logic [2:0]      hsize,
  input  logic            hwrite,
  output logic [IDXW-1:0] idx,
  output logic [NSLV-1:0] sel,
  output logic [3:0]      pstrb,
  output logic            err
);

  // Only the index field and the two lowest bits matter here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^haddr;

  generate
    if (NSLV > 1) begin : g_idx
      assign idx = haddr[SEL_LSB +: IDXW];
    end else begin : g_idx_single
      assign idx = '0;
    end
  endgenerate

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_sel
    assign sel[gi] = (idx == IDXW'(gi));
  end

  assign pstrb = write_strobe(hsize, haddr[1:0], hwrite);
  // The index test only bites when NSLV is not a power of two.
  assign err   = (32'(idx) >= NSLV) || size_align_err(hsize, haddr[1:0]);

endmodule

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave converting single NONSEQ transfers into APB4
// transfers to one of NSLV peripherals, wait-stated through a small FSM.
//   clk    : clock, all logic on the rising edge
//   resetn : synchronous active-low reset
//   bus    : ahb_apb_bridge_if.slave (AHB-Lite slave side and APB4 master side)
// Parameters: NSLV slaves, SEL_LSB lowest slave-index address bit, TIMEOUT maximum
// ACCESS cycles before the transfer is aborted with ERROR (0 disables the timeout).
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  ahb_apb_bridge_if.slave        bus
);

  localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic [31:0]     hrdata_reg, hrdata_next;
  logic [31:0]     addr_reg;
  logic            write_reg;
  logic [IDXW-1:0] idx_reg;
  logic [NSLV-1:0] sel_reg;
  logic [3:0]      strb_reg;
  logic            derr_reg;
  logic [31:0]     pwdata_reg;

  logic [IDXW-1:0] dec_idx;
  logic [NSLV-1:0] dec_sel;
  logic [3:0]      dec_strb;
  logic            dec_err;

  logic            accept;
  logic            sel_pready;
  logic            sel_pslverr;
  logic            timeout_hit;
  logic [31:0]     prdata_arr [NSLV];

  apb_slave_decode #(
    .NSLV    (NSLV),
    .SEL_LSB (SEL_LSB)
  ) u_decode (
    .haddr  (bus.haddr),
    .hsize  (bus.hsize),
    .hwrite (bus.hwrite),
    .idx    (dec_idx),
    .sel    (dec_sel),
    .pstrb  (dec_strb),
    .err    (dec_err)
  );

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_prdata
    assign prdata_arr[gi] = bus.prdata[32*gi +: 32];
  end

  assign accept      = (state_reg == IDLE) && bus.hsel && bus.hready &&
                       (bus.htrans == HTRANS_NONSEQ);
  assign sel_pready  = bus.pready[idx_reg];
  assign sel_pslverr = bus.pslverr[idx_reg];
  // The counter equals the number of ACCESS cycles already completed, so this is
  // true on the TIMEOUT-th ACCESS cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNTW'(TIMEOUT - 1));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hrdata_next = hrdata_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = LATCH;
      end
      LATCH: begin
        if (derr_reg) begin
          state_next = ERR_1;
        end else begin
          state_next = SETUP;
          cnt_next   = '0;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (TIMEOUT != 0) cnt_next = cnt_reg + CNTW'(1);
        if (sel_pready) begin
          // A slave error leaves the previous read data in place.
          if (!write_reg && !sel_pslverr) hrdata_next = prdata_arr[idx_reg];
          state_next = sel_pslverr ? ERR_1 : IDLE;
        end else if (timeout_hit) begin
          state_next = ERR_1;
        end
      end
      ERR_1:   state_next = ERR_2;
      ERR_2:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hrdata_reg <= '0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      idx_reg    <= '0;
      sel_reg    <= '0;
      strb_reg   <= '0;
      derr_reg   <= 1'b0;
      pwdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hrdata_reg <= hrdata_next;
      if (accept) begin
        addr_reg  <= bus.haddr;
        write_reg <= bus.hwrite;
        idx_reg   <= dec_idx;
        sel_reg   <= dec_sel;
        strb_reg  <= dec_strb;
        derr_reg  <= dec_err;
      end
      // Write data arrives in the AHB data phase, one cycle after the address.
      if (state_reg == LATCH) pwdata_reg <= bus.hwdata;
    end
  end

  assign bus.hreadyout = (state_reg == IDLE) || (state_reg == ERR_2);
  assign bus.hresp     = (state_reg == ERR_1) || (state_reg == ERR_2);
  assign bus.hrdata    = hrdata_reg;
  assign bus.psel      = ((state_reg == SETUP) || (state_reg == ACCESS)) ? sel_reg : '0;
  assign bus.penable   = (state_reg == ACCESS);
  assign bus.paddr     = addr_reg;
  assign bus.pwrite    = write_reg;
  assign bus.pwdata    = pwdata_reg;
  assign bus.pstrb     = strb_reg;

endmodule
